// File: rtl/pc_pkg.sv
// pc_pkg: shared address geometry and reset value for the program counter.
package pc_pkg;
    localparam int ADDR_W = 8;
    localparam int LSB_W = 2;
    localparam int MSB_W = ADDR_W - LSB_W;
    localparam logic [ADDR_W-1:0] RESET_ADDR = 8'h00;
endpackage

// File: rtl/pc_next_addr.sv
// pc_next_addr: priority mux producing the next {msb, lsb} address.
module pc_next_addr #(
    parameter int ADDR_W = pc_pkg::ADDR_W,
    parameter int LSB_W = pc_pkg::LSB_W
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     jump,
    input  logic [ADDR_W-LSB_W-1:0]  jump_destination,
    input  logic                     branch,
    input  logic [ADDR_W-LSB_W-1:0]  branch_offset,
    input  logic                     update_msbs,
    input  logic                     update_lsbs,
    output logic [ADDR_W-1:0]        next_addr
);
    localparam int MSB_W = ADDR_W - LSB_W;
    localparam logic [MSB_W-1:0] MSB_ONE = 1;
    localparam logic [LSB_W-1:0] LSB_ONE = 1;
    localparam logic [LSB_W-1:0] LSB_ZERO = '0;
    logic [MSB_W-1:0] msb;
    logic [LSB_W-1:0] lsb;
    assign msb = addr[ADDR_W-1:LSB_W];
    assign lsb = addr[LSB_W-1:0];
    // Two's-complement offset: plain modular add equals sign-extended add.
    always_comb begin
        next_addr = jump        ? {jump_destination, LSB_ZERO} :
                    branch      ? {msb + branch_offset, LSB_ZERO} :
                    update_msbs ? {msb + MSB_ONE, LSB_ZERO} :
                    update_lsbs ? {msb, lsb + LSB_ONE} :
                                  addr;
    end
endmodule

// File: rtl/program_counter_core.sv
// program_counter_core: registered program counter with async reset.
module program_counter_core #(
    parameter int ADDR_W = pc_pkg::ADDR_W,
    parameter int LSB_W = pc_pkg::LSB_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     update_msbs,
    input  logic                     update_lsbs,
    input  logic                     jump,
    input  logic [ADDR_W-LSB_W-1:0]  jump_destination,
    input  logic                     branch,
    input  logic [ADDR_W-LSB_W-1:0]  branch_offset,
    output logic [ADDR_W-1:0]        mem_addr
);
    import pc_pkg::*;
    logic [ADDR_W-1:0] next_addr;
    pc_next_addr #(.ADDR_W(ADDR_W), .LSB_W(LSB_W)) u_next (
        .addr(mem_addr),
        .jump(jump),
        .jump_destination(jump_destination),
        .branch(branch),
        .branch_offset(branch_offset),
        .update_msbs(update_msbs),
        .update_lsbs(update_lsbs),
        .next_addr(next_addr)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_addr <= ADDR_W'(RESET_ADDR);
        else mem_addr <= next_addr;
    end
endmodule

// File: tb/tb_program_counter_core.sv
// tb_program_counter_core: directed and random checks against an arithmetic reference model.
module tb_program_counter_core;
    import pc_pkg::*;
    logic clk = 0, rst = 0, update_msbs = 0, update_lsbs = 0, jump = 0, branch = 0;
    logic [MSB_W-1:0] jump_destination = '0, branch_offset = '0;
    logic [ADDR_W-1:0] mem_addr;
    int cmp = 0, errs = 0, model = 0;

    always #5 clk = ~clk;

    program_counter_core dut (
        .clk(clk),
        .rst(rst),
        .update_msbs(update_msbs),
        .update_lsbs(update_lsbs),
        .jump(jump),
        .jump_destination(jump_destination),
        .branch(branch),
        .branch_offset(branch_offset),
        .mem_addr(mem_addr)
    );

    // Address treated as word*4 + lane; arithmetic done on plain integers.
    function automatic int ref_next(int a, bit j, int d, bit b, int o, bit m, bit l);
        int word = a / 4;
        int lane = a % 4;
        int soff = (o >= 32) ? o - 64 : o;
        if (j) return d * 4;
        if (b) return (((word + soff) % 64 + 64) % 64) * 4;
        if (m) return ((word + 1) % 64) * 4;
        if (l) return word * 4 + (lane + 1) % 4;
        return a;
    endfunction

    task automatic check(string tag, int exp);
        cmp++;
        assert (mem_addr === ADDR_W'(exp)) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, mem_addr, ADDR_W'(exp));
        end
    endtask

    task automatic step(string tag, bit j, bit b, bit m, bit l, int d, int o, int exp);
        jump = j; branch = b; update_msbs = m; update_lsbs = l;
        jump_destination = MSB_W'(d);
        branch_offset = MSB_W'(o);
        model = ref_next(model, j, d, b, o, m, l);
        @(posedge clk); #1;
        check(tag, exp < 0 ? model : exp);
    endtask

    task automatic idle_inputs();
        jump = 0; branch = 0; update_msbs = 0; update_lsbs = 0;
    endtask

    initial begin
        #2 rst = 1;
        #1 check("rst_async", 0);
        step("rst_hold_cmds", 1, 1, 1, 1, 5, 3, 0);
        step("rst_hold_cmds2", 0, 0, 1, 0, 0, 0, 0);
        model = 0;
        idle_inputs();
        rst = 0;
        step("rst_release_idle", 0, 0, 0, 0, 0, 0, 8'h00);
        step("lsb1", 0, 0, 0, 1, 0, 0, 8'h01);
        step("lsb2", 0, 0, 0, 1, 0, 0, 8'h02);
        step("lsb3", 0, 0, 0, 1, 0, 0, 8'h03);
        step("lsb_wrap", 0, 0, 0, 1, 0, 0, 8'h00);
        step("lsb5", 0, 0, 0, 1, 0, 0, 8'h01);
        step("lsb_hold", 0, 0, 0, 0, 0, 0, 8'h01);
        step("msb_from01", 0, 0, 1, 0, 0, 0, 8'h04);
        step("msb_hold", 0, 0, 0, 0, 0, 0, 8'h04);
        step("msb_08", 0, 0, 1, 0, 0, 0, 8'h08);
        step("lsb_09", 0, 0, 0, 1, 0, 0, 8'h09);
        step("lsb_0a", 0, 0, 0, 1, 0, 0, 8'h0A);
        step("lsb_0b", 0, 0, 0, 1, 0, 0, 8'h0B);
        step("lsb_0b_wrap", 0, 0, 0, 1, 0, 0, 8'h08);
        step("msb_0c", 0, 0, 1, 0, 0, 0, 8'h0C);
        step("jump_0f", 1, 0, 0, 0, 8'h0F, 0, 8'h3C);
        step("jump_0a", 1, 0, 0, 0, 8'h0A, 0, 8'h28);
        step("jump_hold", 0, 0, 0, 0, 0, 0, 8'h28);
        step("branch_m1", 0, 1, 0, 0, 0, 8'h3F, 8'h24);
        step("branch_p4", 0, 1, 0, 0, 0, 8'h04, 8'h34);
        step("jump_00", 1, 0, 0, 0, 0, 0, 8'h00);
        step("branch_wrap", 0, 1, 0, 0, 0, 8'h3F, 8'hFC);
        step("msb_wrap_fc", 0, 0, 1, 0, 0, 0, 8'h00);
        step("jump_3f", 1, 0, 0, 0, 8'h3F, 0, 8'hFC);
        step("lsb_fd", 0, 0, 0, 1, 0, 0, 8'hFD);
        step("lsb_fe", 0, 0, 0, 1, 0, 0, 8'hFE);
        step("lsb_ff", 0, 0, 0, 1, 0, 0, 8'hFF);
        step("msb_wrap_ff", 0, 0, 1, 0, 0, 0, 8'h00);
        step("prio_all", 1, 1, 1, 1, 8'h01, 8'h15, 8'h04);
        step("prio_branch", 0, 1, 1, 0, 0, 8'h02, 8'h0C);
        step("jump_02", 1, 0, 0, 0, 8'h02, 0, 8'h08);
        step("lsb_09b", 0, 0, 0, 1, 0, 0, 8'h09);
        step("prio_msb_lsb", 0, 0, 1, 1, 0, 0, 8'h0C);
        for (int i = 0; i < 300; i++)
            step("rand",
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), -1);
        idle_inputs();
        step("pre_reset_state", 0, 0, 0, 0, 0, 0, -1);
        #3 rst = 1;
        #1 check("rst_mid_cycle", 0);
        model = 0;
        #2 rst = 0;
        step("rst_mid_release", 0, 0, 0, 0, 0, 0, 8'h00);
        step("post_reset_lsb", 0, 0, 0, 1, 0, 0, 8'h01);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
